// File: rtl/top_global_fused.sv
// Fused two-layer int8 MLP over a shared 128-bit global BRAM: host load/readback phase,
// then an in-place compute pass of 5 cycles per IFM word (read IFM, W1, W2, calc, write).
module top_global_fused #(
  parameter int MEM_DEPTH = 4096,
  parameter int AW        = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  base_addr_IFM,
  input  logic [31:0]  size_IFM,
  input  logic [31:0]  base_addr_Weight_layer_1,
  input  logic [31:0]  size_Weight_layer_1,
  input  logic [31:0]  base_addr_Weight_layer_2,
  input  logic [31:0]  size_Weight_layer_2,
  input  logic [31:0]  wr_addr_global_intial,
  input  logic [31:0]  rd_addr_global_intial,
  input  logic [127:0] data_load_in_global,
  input  logic         we_global_initial,
  input  logic         load_phase,
  output logic [127:0] rd_data_global,
  output logic         busy,
  output logic         done,
  output logic         ofm_valid,
  output logic [31:0]  ofm_addr,
  output logic [127:0] ofm_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_IFM, S_RD_W1, S_RD_W2, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [127:0] mem [MEM_DEPTH];
  logic [127:0] mem_q;

  logic         lp_q;
  logic [31:0]  ifm_base, ifm_size, w1_base, w1_size, w2_base, w2_size;
  logic [31:0]  cnt, w1_idx, w2_idx;
  logic [127:0] ifm_word, w1_word, w2_word, result;

  logic         start;
  logic         host_we, fsm_we;
  logic [31:0]  rd_sel, wr_sel;
  logic [AW-1:0] rd_idx;
  logic         addr_hi_unused;

  function automatic logic signed [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127) return 8'sh7f;
    if (v < -16'sd128) return 8'sh80;
    return v[7:0];
  endfunction

  function automatic logic [7:0] fuse_lane(input logic signed [7:0] x,
                                           input logic signed [7:0] wa,
                                           input logic signed [7:0] wb);
    logic signed [15:0] xe, wae, wbe, le, p;
    logic signed [7:0]  l1;
    xe  = x;
    wae = wa;
    wbe = wb;
    p   = xe * wae;
    l1  = sat8(p >>> 7);
    if (l1[7]) l1 = '0;
    le  = l1;
    p   = le * wbe;
    return sat8(p >>> 7);
  endfunction

  // Weight rows are reused cyclically; the index wraps instead of using a divider.
  function automatic logic [31:0] next_idx(input logic [31:0] idx, input logic [31:0] size);
    if (({1'b0, idx} + 33'd1) >= {1'b0, size}) return '0;
    return idx + 32'd1;
  endfunction

  always_comb begin
    result = '0;
    for (int k = 0; k < 16; k++) begin
      result[8*k +: 8] = fuse_lane(ifm_word[8*k +: 8], w1_word[8*k +: 8], w2_word[8*k +: 8]);
    end
  end

  assign start   = lp_q & ~load_phase & ((state == S_IDLE) | (state == S_DONE));
  assign host_we = load_phase & we_global_initial;
  assign fsm_we  = (state == S_WRITE) & ~load_phase & reset_n;
  assign wr_sel  = ifm_base + cnt;
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);

  // The host owns the single read port whenever load_phase is high.
  always_comb begin
    rd_sel = rd_addr_global_intial;
    if (!load_phase) begin
      case (state)
        S_RD_IFM: rd_sel = ifm_base + cnt;
        S_RD_W1:  rd_sel = w1_base + w1_idx;
        S_RD_W2:  rd_sel = w2_base + w2_idx;
        default:  rd_sel = rd_addr_global_intial;
      endcase
    end
  end

  assign rd_idx = rd_sel[AW-1:0];
  assign addr_hi_unused = ^{rd_sel[31:AW], wr_addr_global_intial[31:AW]};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (size_IFM == 32'd0) ? S_DONE : S_RD_IFM;
      end
      S_DONE: begin
        if (load_phase)  state_nx = S_IDLE;
        else if (start)  state_nx = (size_IFM == 32'd0) ? S_DONE : S_RD_IFM;
      end
      S_RD_IFM: state_nx = load_phase ? S_IDLE : S_RD_W1;
      S_RD_W1:  state_nx = load_phase ? S_IDLE : S_RD_W2;
      S_RD_W2:  state_nx = load_phase ? S_IDLE : S_CALC;
      S_CALC:   state_nx = load_phase ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (load_phase) state_nx = S_IDLE;
        else if (({1'b0, cnt} + 33'd1) < {1'b0, ifm_size}) state_nx = S_RD_IFM;
        else state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Contents survive reset; read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    mem_q <= mem[rd_idx];
    if (host_we)     mem[wr_addr_global_intial[AW-1:0]] <= data_load_in_global;
    else if (fsm_we) mem[wr_sel[AW-1:0]] <= result;
  end

  // ofm_valid is a single-cycle pulse per written word; there is no back-pressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      lp_q           <= 1'b0;
      ifm_base       <= '0;
      ifm_size       <= '0;
      w1_base        <= '0;
      w1_size        <= '0;
      w2_base        <= '0;
      w2_size        <= '0;
      cnt            <= '0;
      w1_idx         <= '0;
      w2_idx         <= '0;
      ifm_word       <= '0;
      w1_word        <= '0;
      w2_word        <= '0;
      rd_data_global <= '0;
      ofm_valid      <= 1'b0;
      ofm_addr       <= '0;
      ofm_data       <= '0;
    end else begin
      state     <= state_nx;
      lp_q      <= load_phase;
      ofm_valid <= 1'b0;
      if (load_phase) rd_data_global <= mem[rd_idx];
      if (start) begin
        ifm_base <= base_addr_IFM;
        ifm_size <= size_IFM;
        w1_base  <= base_addr_Weight_layer_1;
        w1_size  <= size_Weight_layer_1;
        w2_base  <= base_addr_Weight_layer_2;
        w2_size  <= size_Weight_layer_2;
        cnt      <= '0;
        w1_idx   <= '0;
        w2_idx   <= '0;
      end
      case (state)
        S_RD_W1: ifm_word <= mem_q;
        S_RD_W2: w1_word  <= (w1_size == 32'd0) ? '0 : mem_q;
        S_CALC:  w2_word  <= (w2_size == 32'd0) ? '0 : mem_q;
        S_WRITE: begin
          if (!load_phase) begin
            ofm_valid <= 1'b1;
            ofm_addr  <= wr_sel;
            ofm_data  <= result;
            cnt       <= cnt + 32'd1;
            w1_idx    <= next_idx(w1_idx, w1_size);
            w2_idx    <= next_idx(w2_idx, w2_size);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_global_fused.sv
// Bench for top_global_fused: directed and randomized jobs checked against a
// word-level reference model of the global memory and the lane arithmetic.
module tb_top_global_fused;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  base_addr_IFM, size_IFM;
  logic [31:0]  base_addr_Weight_layer_1, size_Weight_layer_1;
  logic [31:0]  base_addr_Weight_layer_2, size_Weight_layer_2;
  logic [31:0]  wr_addr_global_intial, rd_addr_global_intial;
  logic [127:0] data_load_in_global;
  logic         we_global_initial;
  logic         load_phase;
  logic [127:0] rd_data_global;
  logic         busy, done, ofm_valid;
  logic [31:0]  ofm_addr;
  logic [127:0] ofm_data;

  logic [127:0] mm [4096];
  int n_vec = 0;
  int n_err = 0;

  top_global_fused dut (
    .clk(clk), .reset_n(reset_n),
    .base_addr_IFM(base_addr_IFM), .size_IFM(size_IFM),
    .base_addr_Weight_layer_1(base_addr_Weight_layer_1), .size_Weight_layer_1(size_Weight_layer_1),
    .base_addr_Weight_layer_2(base_addr_Weight_layer_2), .size_Weight_layer_2(size_Weight_layer_2),
    .wr_addr_global_intial(wr_addr_global_intial), .rd_addr_global_intial(rd_addr_global_intial),
    .data_load_in_global(data_load_in_global), .we_global_initial(we_global_initial),
    .load_phase(load_phase), .rd_data_global(rd_data_global),
    .busy(busy), .done(done), .ofm_valid(ofm_valid), .ofm_addr(ofm_addr), .ofm_data(ofm_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model --------------------------------------------------
  function automatic int floor128(input int p);
    if (p >= 0) return p / 128;
    return -((-p + 127) / 128);
  endfunction

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic [127:0] ref_word(input logic [127:0] x, input logic [127:0] wa,
                                            input logic [127:0] wb);
    logic [127:0] r;
    int a, b, c, l1, o;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      a  = $signed(x[8*k +: 8]);
      b  = $signed(wa[8*k +: 8]);
      c  = $signed(wb[8*k +: 8]);
      l1 = clamp8(floor128(a * b));
      if (l1 < 0) l1 = 0;
      o  = clamp8(floor128(l1 * c));
      r[8*k +: 8] = o[7:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] weight_at(input logic [31:0] base, input logic [31:0] size,
                                             input int i);
    logic [31:0] a;
    if (size == 0) return '0;
    a = base + 32'(i % int'(size));
    return mm[a[11:0]];
  endfunction

  // ---- driver tasks -----------------------------------------------------
  task automatic host_write(input logic [31:0] addr, input logic [127:0] data);
    @(negedge clk);
    load_phase = 1'b1;
    we_global_initial = 1'b1;
    wr_addr_global_intial = addr;
    data_load_in_global = data;
    @(posedge clk);
    #1;
    we_global_initial = 1'b0;
    mm[addr[11:0]] = data;
  endtask

  task automatic host_read(input string tag, input logic [31:0] addr, input logic [127:0] exp);
    @(negedge clk);
    load_phase = 1'b1;
    rd_addr_global_intial = addr;
    @(posedge clk);
    #1;
    check(tag, rd_data_global, exp);
  endtask

  // abort_kind: 0 none, 1 raise load_phase after cycle abort_at, 2 reset after cycle abort_at
  task automatic run_job(input logic [31:0] ib, input logic [31:0] isz,
                         input logic [31:0] w1b, input logic [31:0] w1s,
                         input logic [31:0] w2b, input logic [31:0] w2s,
                         input int abort_at, input int abort_kind);
    int total, k;
    logic exp_valid;
    logic [31:0] a;
    logic [127:0] r;
    total = 5 * int'(isz) + 1;
    @(negedge clk);
    base_addr_IFM = ib;              size_IFM = isz;
    base_addr_Weight_layer_1 = w1b;  size_Weight_layer_1 = w1s;
    base_addr_Weight_layer_2 = w2b;  size_Weight_layer_2 = w2s;
    we_global_initial = 1'b0;
    load_phase = 1'b0;
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 3) begin
        base_addr_IFM = $urandom;  size_IFM = $urandom;
        base_addr_Weight_layer_1 = $urandom;  size_Weight_layer_1 = $urandom;
        base_addr_Weight_layer_2 = $urandom;  size_Weight_layer_2 = $urandom;
      end
      exp_valid = (cyc >= 6) && ((cyc - 1) % 5 == 0);
      check("ofm_valid", {127'd0, ofm_valid}, {127'd0, exp_valid});
      if (exp_valid) begin
        k = (cyc - 6) / 5;
        a = ib + 32'(k);
        r = ref_word(mm[a[11:0]], weight_at(w1b, w1s, k), weight_at(w2b, w2s, k));
        check("ofm_addr", {96'd0, ofm_addr}, {96'd0, a});
        check("ofm_data", ofm_data, r);
        mm[a[11:0]] = r;
      end
      check("busy", {127'd0, busy}, {127'd0, (cyc < total)});
      check("done", {127'd0, done}, {127'd0, (cyc >= total)});
      if (abort_kind != 0 && cyc == abort_at) break;
    end
    @(negedge clk);
    if (abort_kind == 2) reset_n = 1'b0;
    else load_phase = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after", {127'd0, busy}, 128'd0);
    check("done_after", {127'd0, done}, 128'd0);
    check("ofm_valid_after", {127'd0, ofm_valid}, 128'd0);
    if (abort_kind == 2) begin
      check("rst_rd_data", rd_data_global, 128'd0);
      check("rst_ofm_addr", {96'd0, ofm_addr}, 128'd0);
      check("rst_ofm_data", ofm_data, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      load_phase = 1'b1;
    end
    for (int i = 0; i < int'(isz); i++) begin
      a = ib + 32'(i);
      host_read("readback", a, mm[a[11:0]]);
    end
  endtask

  // ---- stimulus ---------------------------------------------------------
  initial begin
    logic [127:0] old_v, new_v, x;
    int isz, w1s, w2s, ab, at;
    reset_n = 1'b0;
    load_phase = 1'b1;
    we_global_initial = 1'b0;
    wr_addr_global_intial = '0;
    rd_addr_global_intial = '0;
    data_load_in_global = '0;
    base_addr_IFM = '0;  size_IFM = '0;
    base_addr_Weight_layer_1 = '0;  size_Weight_layer_1 = '0;
    base_addr_Weight_layer_2 = '0;  size_Weight_layer_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    check("reset_ofm_valid", {127'd0, ofm_valid}, 128'd0);
    check("reset_ofm_addr", {96'd0, ofm_addr}, 128'd0);
    check("reset_ofm_data", ofm_data, 128'd0);
    check("reset_rd_data", rd_data_global, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 64; i++) host_write(32'(i), {$urandom, $urandom, $urandom, $urandom});
    host_write(32'd4094, {$urandom, $urandom, $urandom, $urandom});
    host_write(32'd4095, {$urandom, $urandom, $urandom, $urandom});

    host_write(32'd0, 128'hDEADBEEF_CAFECAFE_BADC0DE0_12345678);
    host_read("load_readback", 32'd0, 128'hDEADBEEF_CAFECAFE_BADC0DE0_12345678);

    old_v = mm[5];
    new_v = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    we_global_initial = 1'b1;
    wr_addr_global_intial = 32'd5;
    rd_addr_global_intial = 32'd5;
    data_load_in_global = new_v;
    @(posedge clk);
    #1;
    we_global_initial = 1'b0;
    check("collision_old", rd_data_global, old_v);
    mm[5] = new_v;
    host_read("collision_new", 32'd5, new_v);

    host_write(32'd10, {16{8'h40}});
    host_write(32'd20, {16{8'h40}});
    host_write(32'd30, {16{8'h7f}});
    run_job(32'd10, 32'd1, 32'd20, 32'd1, 32'd30, 32'd1, 0, 0);
    host_read("all_0x1f", 32'd10, {16{8'h1f}});

    x = '0;  x[7:0] = 8'h80;  x[15:8] = 8'h80;
    host_write(32'd11, x);
    x = '0;  x[7:0] = 8'h80;  x[15:8] = 8'h40;
    host_write(32'd21, x);
    x = '0;  x[7:0] = 8'h7f;  x[15:8] = 8'h7f;
    host_write(32'd31, x);
    run_job(32'd11, 32'd1, 32'd21, 32'd1, 32'd31, 32'd1, 0, 0);
    host_read("sat_relu", 32'd11, 128'h7e);

    run_job(32'd40, 32'd3, 32'd20, 32'd2, 32'd30, 32'd1, 0, 0);
    run_job(32'd50, 32'd0, 32'd20, 32'd1, 32'd30, 32'd1, 0, 0);
    host_read("size0_untouched", 32'd50, mm[50]);
    run_job(32'd44, 32'd3, 32'd22, 32'd3, 32'd33, 32'd2, 8, 1);
    run_job(32'd47, 32'd3, 32'd24, 32'd0, 32'd35, 32'd2, 12, 2);
    run_job(32'hFFFF_FFFE, 32'd3, 32'd1, 32'd2, 32'd3, 32'd3, 0, 0);
    host_read("wrap_word0", 32'd0, mm[0]);

    for (int j = 0; j < 20; j++) begin
      if ($urandom_range(0, 1) == 1)
        host_write(32'($urandom_range(0, 63)), {$urandom, $urandom, $urandom, $urandom});
      isz = $urandom_range(0, 4);
      w1s = $urandom_range(0, 4);
      w2s = $urandom_range(0, 4);
      ab  = 0;
      at  = 0;
      if (isz > 0 && $urandom_range(0, 4) == 0) begin
        ab = $urandom_range(1, 2);
        at = $urandom_range(1, 5 * isz);
      end
      run_job(32'($urandom_range(0, 56)), 32'(isz), 32'($urandom_range(0, 56)), 32'(w1s),
              32'($urandom_range(0, 56)), 32'(w2s), at, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/top_global_fused.md
TOP_GLOBAL_FUSED -- requirements
Module: top_global_fused

Interface
REQ-001 Ports: one clock, clk; reset is synchronous and active-low, reset_n. Both SHALL be sampled on the rising edge of clk.
REQ-002 Parameter MEM_DEPTH, default 4096, number of 128-bit global BRAM words.
REQ-003 Parameter AW, default 12, BRAM index width; index = addr[AW-1:0], wrapping modulo MEM_DEPTH.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 base_addr_IFM  input  32  word address of the IFM; results are written back in place.
REQ-007 size_IFM  input  32  IFM length in 128-bit words.
REQ-008 base_addr_Weight_layer_1 / size_Weight_layer_1  input  32/32  layer-1 weight base and length in words.
REQ-009 base_addr_Weight_layer_2 / size_Weight_layer_2  input  32/32  layer-2 weight base and length in words.
REQ-010 wr_addr_global_intial  input  32  load-phase write address.
REQ-011 rd_addr_global_intial  input  32  load-phase readback address.
REQ-012 data_load_in_global  input  128  load-phase write data.
REQ-013 we_global_initial  input  1  load-phase write enable.
REQ-014 load_phase  input  1  1 = host owns the BRAM; its 1->0 transition starts compute.
REQ-015 rd_data_global  output  128  registered readback data.
REQ-016 busy / done  output  1/1  compute in progress / compute finished.
REQ-017 ofm_valid / ofm_addr / ofm_data  output  1/32/128  one-cycle pulse per result word, with its address and data.

Function
REQ-018 Load: when load_phase=1 and we_global_initial=1, mem[wr_addr_global_intial] SHALL be written with data_load_in_global at the clock edge.
REQ-019 Readback: while load_phase=1, rd_data_global SHALL equal mem[rd_addr_global_intial] one cycle after the address is presented (read-before-write on a same-address collision).
REQ-020 Start: a registered detection of load_phase 1->0 while the FSM is in IDLE or DONE SHALL start compute.
REQ-021 Start when size_IFM=0: the FSM SHALL go straight to DONE.
REQ-022 FSM states: IDLE, RD_IFM, RD_W1, RD_W2, CALC, WRITE, DONE.
REQ-023 Per word i, one state per cycle, 5 cycles per word:
- RD_IFM issues base_addr_IFM+i.
- RD_W1 captures the IFM word and issues W1 address.
- RD_W2 captures the W1 word and issues W2 address.
- CALC captures the W2 word.
- WRITE writes the result and pulses ofm_valid.
REQ-024 Weight index SHALL be i mod size_Weight_layer_n; if that size is 0, the weight word SHALL be all zeros.
REQ-025 Lane arithmetic: 16 signed 8-bit lanes, lane k = bits [8k+7:8k].
- l1 = ReLU(sat8((ifm*w1) >>> 7)).
- out = sat8((l1*w2) >>> 7).
- sat8 clamps to [-128, 127]; products are 16-bit signed; the shift is arithmetic (floor).
REQ-026 In WRITE: mem[base_addr_IFM+i] <= result, ofm_addr = base_addr_IFM+i, ofm_data = result.
- If i+1 < size_IFM: go to RD_IFM with i+1.
- Otherwise: go to DONE.
REQ-027 busy SHALL be 1 in every state except IDLE and DONE; done SHALL be 1 only in DONE.
REQ-028 DONE SHALL hold until load_phase rises, then go to IDLE.
REQ-029 Abort: load_phase=1 in any busy state SHALL return the FSM to IDLE next cycle with no further writes; done stays 0.
REQ-030 Host writes (REQ-018) SHALL be ignored while load_phase=0.
REQ-031 Base/size inputs SHALL be latched at start; later changes SHALL not affect the running job.
REQ-032 Word counter SHALL be 32 bits; address sums SHALL wrap modulo 2^32 before indexing.

Reset
REQ-033 reset_n=0 at a clock edge SHALL force:
- FSM to IDLE.
- Counter and latched registers to 0.
- rd_data_global, ofm_addr and ofm_data to 0.
- busy, done and ofm_valid to 0.
- Edge-detect register to 0.
REQ-034 BRAM contents SHALL NOT be cleared by reset.
REQ-035 Reset asserted mid-compute SHALL abort with no further writes.

Verification
REQ-036 Load/readback: load_phase=1, we=1, wr_addr=0, data=0xDEADBEEF_CAFECAFE_BADC0DE0_12345678, then rd_addr=0 -> rd_data_global equals that value one cycle later.
REQ-037 Compute: IFM lanes all 0x40, W1 all 0x40, W2 all 0x7F, sizes 1/1/1, drop load_phase -> one ofm_valid, all lanes 0x1F, done high 6 cycles after the 1->0 edge.
REQ-038 Negative/saturate: IFM lane0=0x80, W1 lane0=0x80, W2 lane0=0x7F -> l1=127 (saturated), out=0x7E; IFM 0x80 with W1 0x40 -> out 0x00 (ReLU).
REQ-039 Multi-word: size_IFM=3, size_W1=2 -> 3 ofm_valid pulses 5 cycles apart, W1 indices 0,1,0, in-place results read back during the next load phase.
REQ-040 Boundaries: size_IFM=0 -> done with no writes; load_phase raised mid-compute -> busy drops next cycle, done stays 0; reset mid-compute -> all outputs 0.
